hht_mem_arbiter: RTL

- Round-robin arbiter that shares one read-only memory port between the HHT SpMV fetch engines.
- Four requesters: row-pointer fetcher, column-index fetcher, matrix-value fetcher, vector-value fetcher.
- Issues at most one read per cycle to a fixed-latency memory.
- Routes each returned word back to the requester that issued it, using an in-flight ID pipeline.

---
 rtl/hht_pkg.sv | 36 +++
 rtl/hht_rr_pick.sv | 40 ++++
 rtl/hht_mem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hht_pkg.sv
// Shared types for the HHT SpMV memory arbiter: requester ids, in-flight read
// tracking and the arbitration FSM register set.
package hht_pkg;

    typedef logic [2:0] req_id_t;

    localparam int REQ_ROWPTR = 0;
    localparam int REQ_COLIDX = 1;
    localparam int REQ_MATVAL = 2;
    localparam int REQ_VECVAL = 3;

    localparam logic [2:0] PERF_SEL_DENY = 3'd7;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } inflight_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Whole arbitration FSM in one struct so it can be probed as a unit.
    typedef struct packed {
        arb_state_t state;
        req_id_t    owner;
        req_id_t    ptr;
        logic [3:0] burst_cnt;
    } arb_regs_t;

    function automatic req_id_t next_id(input req_id_t id, input int nreq);
        return (int'(id) == nreq - 1) ? '0 : id + 3'd1;
    endfunction

endpackage

// File: rtl/hht_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping past NREQ-1 back to index 0.
module hht_rr_pick
    import hht_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  req_id_t         ptr,
    output logic [NREQ-1:0] gnt,
    output req_id_t         gnt_idx
);

    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    logic [2*NREQ-1:0] rot;
    logic              found;
    int                sum;

    // Rotating a doubled copy keeps every bit select constant.
    always_comb begin
        rot     = {req, req} >> ptr;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = int'(ptr) + k;
                if (sum >= NREQ) begin
                    sum = sum - NREQ;
                end
                gnt_idx = req_id_t'(sum);
                gnt     = ONE << gnt_idx;
            end
        end
    end

endmodule

// File: rtl/hht_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency read port between the HHT
// fetch engines. Define HHT_ARB_PERF_EN to build the grant/deny counters.
module hht_mem_arbiter
    import hht_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RD_LAT    = 2,
    parameter int BURST_MAX = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_addr,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [DW-1:0]     rdata,
    output logic              mem_rd,
    output logic [AW-1:0]     mem_addr,
    input  logic [DW-1:0]     mem_rdata,
    input  logic [2:0]        perf_sel,
    output logic [31:0]       perf_cnt
);

    localparam logic [NREQ-1:0] ONE       = NREQ'(1);
    localparam logic [3:0]      BURST_LIM = 4'(BURST_MAX);

    arb_regs_t       arb;
    logic [NREQ-1:0] owner_mask;
    logic [NREQ-1:0] pick_gnt;
    req_id_t         pick_idx;
    req_id_t         search_ptr;
    req_id_t         gnt_idx;
    logic            keep_owner;
    inflight_t       pipe [RD_LAT];

    // The owner keeps the port unless it drops req or has used its burst
    // while someone else waits; otherwise search restarts just past it.
    always_comb begin
        owner_mask = ONE << arb.owner;
        search_ptr = (arb.state == ARB_GRANT) ? next_id(arb.owner, NREQ) : arb.ptr;
        keep_owner = (arb.state == ARB_GRANT) && ((req & owner_mask) != '0)
                     && !(((req & ~owner_mask) != '0) && (arb.burst_cnt == BURST_LIM));
    end

    hht_rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (req),
        .ptr     (search_ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx)
    );

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        if (!Rst) begin
            gnt     = keep_owner ? owner_mask : pick_gnt;
            gnt_idx = keep_owner ? arb.owner  : pick_idx;
        end
        mem_rd   = |gnt;
        mem_addr = mem_rd ? req_addr[int'(gnt_idx)*AW +: AW] : '0;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            arb <= '{state: ARB_IDLE, owner: '0, ptr: '0, burst_cnt: '0};
        end else if (keep_owner) begin
            if (arb.burst_cnt != BURST_LIM) begin
                arb.burst_cnt <= arb.burst_cnt + 4'd1;
            end
        end else begin
            arb.ptr <= search_ptr;
            if (pick_gnt != '0) begin
                arb.state     <= ARB_GRANT;
                arb.owner     <= pick_idx;
                arb.burst_cnt <= 4'd1;
            end else begin
                arb.state     <= ARB_IDLE;
                arb.burst_cnt <= '0;
            end
        end
    end

    // Issue ids ride alongside the memory latency; reset drops them all.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            pipe[0] <= '{valid: mem_rd, id: gnt_idx};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            rvalid <= pipe[RD_LAT-1].valid ? (ONE << pipe[RD_LAT-1].id) : '0;
            if (pipe[RD_LAT-1].valid) begin
                rdata <= mem_rdata;
            end
        end
    end

`ifdef HHT_ARB_PERF_EN
    logic [31:0] grant_cnt [NREQ];
    logic [31:0] deny_cnt;
    logic [31:0] perf_next;

    always_comb begin
        perf_next = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (perf_sel == 3'(i)) begin
                perf_next = grant_cnt[i];
            end
        end
        if (perf_sel == PERF_SEL_DENY) begin
            perf_next = deny_cnt;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NREQ; i++) begin
                grant_cnt[i] <= '0;
            end
            deny_cnt <= '0;
            perf_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] && (grant_cnt[i] != '1)) begin
                    grant_cnt[i] <= grant_cnt[i] + 32'd1;
                end
            end
            if (((req & ~gnt) != '0) && (deny_cnt != '1)) begin
                deny_cnt <= deny_cnt + 32'd1;
            end
            perf_cnt <= perf_next;
        end
    end
`else
    logic unused_perf_sel;
    assign unused_perf_sel = ^perf_sel;
    assign perf_cnt        = '0;
`endif

endmodule
